sdram_io: RTL and testbench

SDRAM command/pin controller at the far end of the arbiter's command interface. It accepts one `SDRAM_PKG::cmd_t` per cycle over a req/ack handshake and drives the registered SDRAM pins. For write bursts it streams write data. For read bursts it captures returning DQ data and presents it with its source tag after CAS latency. It is the sole driver of the external SDRAM bus.

---
 rtl/sdram_io_pkg.sv | 64 ++++++
 rtl/sdram_io_rd_pipe.sv | 67 ++++++
 rtl/sdram_io.sv | 171 +++++++++++++++++
 tb/tb_sdram_io.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_io_pkg.sv
// Shared SDRAM types, timing tables and command-to-pin encoding for sdram_io.
// Optional build macro used by the importers: SDRAM_IO_IOREG_EN (extra DQ input register).
package sdram_io_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned BANK_W   = 2;
    localparam int unsigned ROW_W    = 13;
    localparam int unsigned DQM_W    = DATA_W / 8;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned PALL_BIT = 10;
    localparam int unsigned A10_BIT  = 10;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [BANK_W-1:0] bank_t;
    typedef logic [ROW_W-1:0]  row_t;

    typedef enum logic {CAS_2, CAS_3} cas_t;
    typedef enum logic [1:0] {BURST_1, BURST_2, BURST_4, BURST_8} burst_t;

    localparam int unsigned N_CAS    [2] = '{32'd2, 32'd3};
    localparam int unsigned N_BURSTS [4] = '{32'd1, 32'd2, 32'd4, 32'd8};

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_ACT   = 3'd1,
        OP_READ  = 3'd2,
        OP_WRITE = 3'd3,
        OP_PRE   = 3'd4,
        OP_REF   = 3'd5,
        OP_MRS   = 3'd6
    } op_t;

    typedef struct packed {
        op_t   op;
        bank_t bank;
        row_t  addr;
        data_t data;
    } cmd_t;

    typedef struct packed {
        logic cs_n;
        logic ras_n;
        logic cas_n;
        logic we_n;
    } pins_t;

    // {CS_N, RAS_N, CAS_N, WE_N} for each op; anything unknown is a NOP.
    function automatic pins_t op_pins(input op_t op);
        pins_t p;
        case (op)
            OP_ACT:   p = pins_t'(4'b0011);
            OP_READ:  p = pins_t'(4'b0101);
            OP_WRITE: p = pins_t'(4'b0100);
            OP_PRE:   p = pins_t'(4'b0010);
            OP_REF:   p = pins_t'(4'b0001);
            OP_MRS:   p = pins_t'(4'b0000);
            default:  p = pins_t'(4'b0111);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sdram_io_rd_pipe.sv
// Read return path: tag delay line aligned to the first captured DQ word.
// SDRAM_IO_IOREG_EN adds a pad register ahead of the capture register (+1 latency).
module sdram_io_rd_pipe
    import sdram_io_pkg::*;
#(
    parameter int unsigned NCAS = 3
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  tag_t  i_tag,
    input  data_t i_dq,
    output data_t o_data,
    output tag_t  o_tag
);

`ifdef SDRAM_IO_IOREG_EN
    localparam int unsigned DEPTH = NCAS + 2;
`else
    localparam int unsigned DEPTH = NCAS + 1;
`endif

    tag_t  r_tag_dly [DEPTH];
    tag_t  r_tag;
    data_t r_data;

    // Tag delay line; reset discards tags still in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_tag_dly[i] <= '0;
            end
            r_tag <= '0;
        end else begin
            r_tag_dly[0] <= i_tag;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_tag_dly[i] <= r_tag_dly[i-1];
            end
            r_tag <= r_tag_dly[DEPTH-1];
        end
    end

`ifdef SDRAM_IO_IOREG_EN
    data_t r_pad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pad  <= '0;
            r_data <= '0;
        end else begin
            r_pad  <= i_dq;
            r_data <= r_pad;
        end
    end
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= i_dq;
        end
    end
`endif

    assign o_data = r_data;
    assign o_tag  = r_tag;

endmodule

// File: rtl/sdram_io.sv
// SDRAM command/pin controller: registered command pins, write burst data, tagged read return.
// Build option SDRAM_IO_IOREG_EN: extra DQ input register stage, read latency +1.
module sdram_io
    import sdram_io_pkg::*;
#(
    parameter cas_t   CAS   = CAS_3,
    parameter burst_t BURST = BURST_8
) (
    input  logic              CLK,
    input  logic              RESET_N_IN,
    input  cmd_t              CMD_DATA_IN,
    input  logic              CMD_REQ_IN,
    output logic              CMD_ACK_OUT,
    output data_t             READ_DATA_OUT,
    output tag_t              READ_TAG_OUT,
    output logic              SDRAM_CKE_OUT,
    output logic              SDRAM_CS_N_OUT,
    output logic              SDRAM_RAS_N_OUT,
    output logic              SDRAM_CAS_N_OUT,
    output logic              SDRAM_WE_N_OUT,
    output logic [BANK_W-1:0] SDRAM_BA_OUT,
    output logic [ROW_W-1:0]  SDRAM_A_OUT,
    output logic [DQM_W-1:0]  SDRAM_DQM_OUT,
    output data_t             SDRAM_DQ_OUT,
    output logic              SDRAM_DQ_OE_OUT,
    input  data_t             SDRAM_DQ_IN
);

    localparam int unsigned NCAS   = N_CAS[CAS];
    localparam int unsigned NBURST = N_BURSTS[BURST];
`ifdef SDRAM_IO_IOREG_EN
    localparam int unsigned RD_LOAD = NCAS + NBURST + 1;
`else
    localparam int unsigned RD_LOAD = NCAS + NBURST;
`endif

    logic             w_is_rd;
    logic             w_is_wr;
    logic             w_ack;
    logic             w_accept;
    tag_t             w_rd_tag;
    pins_t            w_pins;
    bank_t            w_ba;
    row_t             w_a;

    logic             r_cke;
    logic [DQM_W-1:0] r_dqm;
    pins_t            r_pins;
    bank_t            r_ba;
    row_t             r_a;
    data_t            r_dq;
    logic             r_oe;
    logic             r_wr_burst;
    logic [CNT_W-1:0] r_burst_cnt;
    logic [CNT_W-1:0] r_rd_cnt;

    // Accept gating: one burst on DQ at a time, plus a turnaround gap before a write.
    always_comb begin
        w_is_rd  = (CMD_DATA_IN.op == OP_READ);
        w_is_wr  = (CMD_DATA_IN.op == OP_WRITE);
        w_ack    = r_cke
                 && !((w_is_rd || w_is_wr) && (r_burst_cnt != '0))
                 && !(w_is_wr && (r_rd_cnt != '0));
        w_accept = CMD_REQ_IN && w_ack;
        w_rd_tag = (w_accept && w_is_rd) ? CMD_DATA_IN.data[TAG_W-1:0] : '0;
    end

    // Next pin values; BA/A hold their last value on NOP cycles.
    always_comb begin
        w_pins = op_pins(OP_NOP);
        w_ba   = r_ba;
        w_a    = r_a;
        if (w_accept) begin
            w_pins = op_pins(CMD_DATA_IN.op);
            case (CMD_DATA_IN.op)
                OP_ACT, OP_MRS: begin
                    w_ba = CMD_DATA_IN.bank;
                    w_a  = CMD_DATA_IN.addr;
                end
                OP_READ, OP_WRITE: begin
                    w_ba         = CMD_DATA_IN.bank;
                    w_a          = CMD_DATA_IN.addr;
                    w_a[A10_BIT] = 1'b0;
                end
                OP_PRE: begin
                    w_ba         = CMD_DATA_IN.bank;
                    w_a          = '0;
                    w_a[A10_BIT] = CMD_DATA_IN.addr[PALL_BIT];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            r_cke  <= 1'b0;
            r_dqm  <= '1;
            r_pins <= pins_t'(4'b1111);
            r_ba   <= '0;
            r_a    <= '0;
        end else begin
            r_cke  <= 1'b1;
            r_dqm  <= '0;
            r_pins <= w_pins;
            r_ba   <= w_ba;
            r_a    <= w_a;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            r_burst_cnt <= '0;
            r_rd_cnt    <= '0;
        end else begin
            if (w_accept && (w_is_rd || w_is_wr)) begin
                r_burst_cnt <= CNT_W'(NBURST - 1);
            end else if (r_burst_cnt != '0) begin
                r_burst_cnt <= r_burst_cnt - CNT_W'(1);
            end
            if (w_accept && w_is_rd) begin
                r_rd_cnt <= CNT_W'(RD_LOAD);
            end else if (r_rd_cnt != '0) begin
                r_rd_cnt <= r_rd_cnt - CNT_W'(1);
            end
        end
    end

    // Write data: first word rides with the command, the rest are sampled live.
    always_ff @(posedge CLK or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            r_dq       <= '0;
            r_oe       <= 1'b0;
            r_wr_burst <= 1'b0;
        end else if (w_accept && w_is_wr) begin
            r_dq       <= CMD_DATA_IN.data;
            r_oe       <= 1'b1;
            r_wr_burst <= 1'b1;
        end else if (r_wr_burst && (r_burst_cnt != '0)) begin
            r_dq       <= CMD_DATA_IN.data;
            r_oe       <= 1'b1;
        end else begin
            r_oe       <= 1'b0;
            r_wr_burst <= 1'b0;
        end
    end

    sdram_io_rd_pipe #(
        .NCAS (NCAS)
    ) u_rd_pipe (
        .i_clk   (CLK),
        .i_rst_n (RESET_N_IN),
        .i_tag   (w_rd_tag),
        .i_dq    (SDRAM_DQ_IN),
        .o_data  (READ_DATA_OUT),
        .o_tag   (READ_TAG_OUT)
    );

    assign CMD_ACK_OUT     = w_ack;
    assign SDRAM_CKE_OUT   = r_cke;
    assign SDRAM_CS_N_OUT  = r_pins.cs_n;
    assign SDRAM_RAS_N_OUT = r_pins.ras_n;
    assign SDRAM_CAS_N_OUT = r_pins.cas_n;
    assign SDRAM_WE_N_OUT  = r_pins.we_n;
    assign SDRAM_BA_OUT    = r_ba;
    assign SDRAM_A_OUT     = r_a;
    assign SDRAM_DQM_OUT   = r_dqm;
    assign SDRAM_DQ_OUT    = r_dq;
    assign SDRAM_DQ_OE_OUT = r_oe;

endmodule

// File: tb/tb_sdram_io.sv
// Scoreboard bench for sdram_io (CAS=3, BURST=8) with a simple SDRAM read-data model.
module tb_sdram_io;
    import sdram_io_pkg::*;

    localparam int NCAS   = 3;
    localparam int NBURST = 8;
`ifdef SDRAM_IO_IOREG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic              clk;
    logic              RESET_N_IN;
    cmd_t              CMD_DATA_IN;
    logic              CMD_REQ_IN;
    logic              CMD_ACK_OUT;
    data_t             READ_DATA_OUT;
    tag_t              READ_TAG_OUT;
    logic              SDRAM_CKE_OUT;
    logic              SDRAM_CS_N_OUT;
    logic              SDRAM_RAS_N_OUT;
    logic              SDRAM_CAS_N_OUT;
    logic              SDRAM_WE_N_OUT;
    logic [BANK_W-1:0] SDRAM_BA_OUT;
    logic [ROW_W-1:0]  SDRAM_A_OUT;
    logic [DQM_W-1:0]  SDRAM_DQM_OUT;
    data_t             SDRAM_DQ_OUT;
    logic              SDRAM_DQ_OE_OUT;
    data_t             SDRAM_DQ_IN;

    sdram_io #(.CAS(CAS_3), .BURST(BURST_8)) dut (
        .CLK             (clk),
        .RESET_N_IN      (RESET_N_IN),
        .CMD_DATA_IN     (CMD_DATA_IN),
        .CMD_REQ_IN      (CMD_REQ_IN),
        .CMD_ACK_OUT     (CMD_ACK_OUT),
        .READ_DATA_OUT   (READ_DATA_OUT),
        .READ_TAG_OUT    (READ_TAG_OUT),
        .SDRAM_CKE_OUT   (SDRAM_CKE_OUT),
        .SDRAM_CS_N_OUT  (SDRAM_CS_N_OUT),
        .SDRAM_RAS_N_OUT (SDRAM_RAS_N_OUT),
        .SDRAM_CAS_N_OUT (SDRAM_CAS_N_OUT),
        .SDRAM_WE_N_OUT  (SDRAM_WE_N_OUT),
        .SDRAM_BA_OUT    (SDRAM_BA_OUT),
        .SDRAM_A_OUT     (SDRAM_A_OUT),
        .SDRAM_DQM_OUT   (SDRAM_DQM_OUT),
        .SDRAM_DQ_OUT    (SDRAM_DQ_OUT),
        .SDRAM_DQ_OE_OUT (SDRAM_DQ_OE_OUT),
        .SDRAM_DQ_IN     (SDRAM_DQ_IN)
    );

    typedef struct {
        tag_t  tag;
        data_t base;
        int    cyc;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    data_t   wr_q[$];

    int    n_chk = 0;
    int    n_err = 0;
    int    cyc   = 0;
    int    nrd   = 0;
    int    n_pin_rd = 0;
    int    n_tag_seen = 0;
    int    data_left = 0;
    int    word_idx = 0;
    data_t rd_base = '0;
    data_t dq_val [4096];
    bit    dq_vld [4096];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] pins_now();
        return {SDRAM_CS_N_OUT, SDRAM_RAS_N_OUT, SDRAM_CAS_N_OUT, SDRAM_WE_N_OUT};
    endfunction

    function automatic cmd_t mk(input op_t op, input bank_t b, input row_t a, input data_t d);
        cmd_t c;
        c.op = op; c.bank = b; c.addr = a; c.data = d;
        return c;
    endfunction

    // Issue one command; acc returns the cycle in which it is on the pins (-1 on timeout).
    task automatic issue(input cmd_t c, input bit stream, output int acc);
        int waited = 0;
        if (c.op == OP_WRITE) begin
            for (int i = 0; i < NBURST; i++) wr_q.push_back(c.data + 16'(i));
        end
        CMD_DATA_IN = c;
        CMD_REQ_IN  = 1'b1;
        acc = -1;
        while (acc < 0 && waited < 64) begin
            @(negedge clk);
            if (CMD_ACK_OUT) acc = cyc + 1;
            @(posedge clk); #1;
            waited++;
        end
        CMD_REQ_IN     = 1'b0;
        CMD_DATA_IN.op = OP_NOP;
        if (acc < 0) begin
            check_eq("ack_timeout", 32'd0, 32'd1);
            return;
        end
        if (c.op == OP_READ) begin
            rd_q.push_back('{c.data[TAG_W-1:0], 16'h1000 + 16'(nrd * 256), acc + NCAS + 1 + LAT});
            nrd++;
        end
        if (c.op == OP_WRITE && stream) begin
            for (int i = 1; i < NBURST; i++) begin
                CMD_DATA_IN.data = c.data + 16'(i);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SDRAM model: a READ on the pins returns base+i on DQ starting NCAS cycles later.
    initial forever begin
        @(negedge clk);
        if (RESET_N_IN && pins_now() == 4'b0101) begin
            for (int i = 0; i < NBURST; i++) begin
                if (cyc + NCAS + i < 4096) begin
                    dq_vld[cyc + NCAS + i] = 1'b1;
                    dq_val[cyc + NCAS + i] = 16'h1000 + 16'(n_pin_rd * 256) + 16'(i);
                end
            end
            n_pin_rd++;
        end
    end

    initial begin
        SDRAM_DQ_IN = '0;
        forever begin
            @(posedge clk); #1;
            SDRAM_DQ_IN = (cyc < 4096 && dq_vld[cyc]) ? dq_val[cyc] : 16'h0;
        end
    end

    // Read scoreboard: tag pops an expectation, then NBURST words follow.
    initial forever begin
        @(negedge clk);
        if (!RESET_N_IN) begin
            data_left = 0;
        end else begin
            if (READ_TAG_OUT != '0) begin
                rd_exp_t e;
                n_tag_seen++;
                if (rd_q.size() == 0) begin
                    check_eq("rd_tag_unexpected", 32'(READ_TAG_OUT), 32'd0);
                end else begin
                    e = rd_q.pop_front();
                    check_eq("rd_tag", 32'(READ_TAG_OUT), 32'(e.tag));
                    check_eq("rd_tag_cycle", 32'(cyc), 32'(e.cyc));
                    data_left = NBURST;
                    word_idx  = 0;
                    rd_base   = e.base;
                end
            end
            if (data_left > 0) begin
                check_eq("rd_data", 32'(READ_DATA_OUT), 32'(rd_base + 16'(word_idx)));
                word_idx++;
                data_left--;
            end
        end
    end

    // Write scoreboard: every OE cycle must match the next queued word.
    initial forever begin
        @(negedge clk);
        if (SDRAM_DQ_OE_OUT) begin
            if (wr_q.size() == 0) check_eq("wr_oe_unexpected", 32'd1, 32'd0);
            else check_eq("wr_dq", 32'(SDRAM_DQ_OUT), 32'(wr_q.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int a1, a2, t0;
        RESET_N_IN  = 1'b0;
        CMD_REQ_IN  = 1'b0;
        CMD_DATA_IN = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_cke",  32'(SDRAM_CKE_OUT), 32'd0);
        check_eq("rst_pins", 32'(pins_now()), 32'hF);
        check_eq("rst_dqm",  32'(SDRAM_DQM_OUT), 32'h3);
        check_eq("rst_ack",  32'(CMD_ACK_OUT), 32'd0);
        check_eq("rst_oe",   32'(SDRAM_DQ_OE_OUT), 32'd0);
        check_eq("rst_tag",  32'(READ_TAG_OUT), 32'd0);
        RESET_N_IN = 1'b1;
        @(negedge clk);
        check_eq("rel_cke",  32'(SDRAM_CKE_OUT), 32'd1);
        check_eq("rel_dqm",  32'(SDRAM_DQM_OUT), 32'd0);
        check_eq("rel_ack",  32'(CMD_ACK_OUT), 32'd1);
        check_eq("rel_pins", 32'(pins_now()), 32'h7);
        @(posedge clk); #1;

        // Encoding: ACT, PRE-all, MRS
        issue(mk(OP_ACT, 2'd2, 13'h1A5, 16'h0), 1'b0, a1);
        @(negedge clk);
        check_eq("act_pins", 32'(pins_now()), 32'h3);
        check_eq("act_ba",   32'(SDRAM_BA_OUT), 32'd2);
        check_eq("act_a",    32'(SDRAM_A_OUT), 32'h1A5);
        @(negedge clk);
        check_eq("act_then_nop", 32'(pins_now()), 32'h7);
        @(posedge clk); #1;
        issue(mk(OP_PRE, 2'd1, 13'h0403, 16'h0), 1'b0, a1);
        @(negedge clk);
        check_eq("pre_pins", 32'(pins_now()), 32'h2);
        check_eq("pre_a10",  32'(SDRAM_A_OUT[10]), 32'd1);
        @(posedge clk); #1;
        issue(mk(OP_MRS, 2'd0, 13'h0033, 16'h0), 1'b0, a1);
        @(negedge clk);
        check_eq("mrs_pins", 32'(pins_now()), 32'h0);
        check_eq("mrs_a",    32'(SDRAM_A_OUT), 32'h033);
        @(posedge clk); #1;

        // Single read, tag 2; column with bit 10 set must go out with A10 clear
        issue(mk(OP_READ, 2'd1, 13'h05FF, 16'h0002), 1'b0, a1);
        @(negedge clk);
        check_eq("rd_pins", 32'(pins_now()), 32'h5);
        check_eq("rd_a",    32'(SDRAM_A_OUT), 32'h01FF);
        idle(16);

        // Single write burst
        issue(mk(OP_WRITE, 2'd0, 13'h0010, 16'h00A0), 1'b1, a1);
        @(negedge clk);
        check_eq("wr_oe_last", 32'(SDRAM_DQ_OE_OUT), 32'd1);
        @(negedge clk);
        check_eq("wr_oe_off",  32'(SDRAM_DQ_OE_OUT), 32'd0);
        check_eq("wr_q_empty", 32'(wr_q.size()), 32'd0);
        @(posedge clk); #1;

        // Back-to-back reads, exactly one burst apart, seamless tags
        issue(mk(OP_READ, 2'd0, 13'h0000, 16'h0003), 1'b0, a1);
        issue(mk(OP_READ, 2'd0, 13'h0008, 16'h0004), 1'b0, a2);
        check_eq("rd_rd_gap", 32'(a2 - a1), 32'(NBURST));
        idle(20);

        // Read-to-write turnaround
        issue(mk(OP_READ, 2'd3, 13'h0020, 16'h0005), 1'b0, a1);
        issue(mk(OP_WRITE, 2'd3, 13'h0028, 16'h00C0), 1'b1, a2);
        check_eq("rd_wr_gap", 32'(a2 - a1), 32'(NCAS + NBURST + 1 + LAT));
        idle(10);
        check_eq("turn_q_empty", 32'(wr_q.size() + rd_q.size()), 32'd0);

        // Reset during write word 4
        issue(mk(OP_WRITE, 2'd0, 13'h0030, 16'h00B0), 1'b0, a1);
        for (int i = 1; i < 4; i++) begin
            CMD_DATA_IN.data = 16'h00B0 + 16'(i);
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        check_eq("mid_oe_before", 32'(SDRAM_DQ_OE_OUT), 32'd1);
        RESET_N_IN = 1'b0;
        #1;
        check_eq("mid_oe_async", 32'(SDRAM_DQ_OE_OUT), 32'd0);
        check_eq("mid_cke",      32'(SDRAM_CKE_OUT), 32'd0);
        wr_q.delete();
        repeat (2) @(negedge clk);
        RESET_N_IN = 1'b1;
        @(negedge clk);
        check_eq("mid_rel_ack", 32'(CMD_ACK_OUT), 32'd1);
        @(posedge clk); #1;

        // Reset with a read in flight: its tag must never appear
        issue(mk(OP_READ, 2'd2, 13'h0040, 16'h0007), 1'b0, a1);
        repeat (2) @(negedge clk);
        #1;
        RESET_N_IN = 1'b0;
        rd_q.delete();
        t0 = n_tag_seen;
        repeat (2) @(negedge clk);
        RESET_N_IN = 1'b1;
        idle(16);
        check_eq("rst_no_tag", 32'(n_tag_seen - t0), 32'd0);
        check_eq("rst_tag_zero", 32'(READ_TAG_OUT), 32'd0);

        idle(4);
        check_eq("end_rd_q", 32'(rd_q.size()), 32'd0);
        check_eq("end_wr_q", 32'(wr_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
